dma_axi_wr_slave: RTL and testbench
===================================

# dma_axi_wr_slave

AXI64 write-channel slave sitting directly downstream of the DMA controller's AXI master port 0. It consumes the AW/W channels (AWID0…WVALID0), writes the data into an internal byte-addressable memory and returns a B response. It gives the DMA top-level bench a real, bounded-latency target, so the AW/W/B handshake properties and the BRESP property are exercised against real RTL.

## Interface
- ID_W, 4, AXI ID width (matches `ID_BITS`)
- LEN_W, 4, burst length width (matches `LEN_BITS`)
- SIZE_W, 2, burst size width (matches `SIZE_BITS`)
- MEM_WORDS, 256, depth of the 64-bit memory (power of 2)
- AW_DLY, 2, cycles from AWVALID seen in IDLE to the AWREADY pulse; legal range 0..4
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- AWID, AWADDR[31:0], AWLEN, AWSIZE, AWVALID  in  per params  write address channel
- AWREADY  out  1  address accept
- WID, WDATA[63:0], WSTRB[7:0], WLAST, WVALID  in  per params  write data channel
- WREADY  out  1  data accept
- BID  out  ID_W  response ID
- BRESP  out  2  0=OKAY, 2=SLVERR
- BVALID  out  1  response valid
- BREADY  in  1  response accept
- dbg_addr  in  log2(MEM_WORDS)  backdoor word index
- dbg_rdata  out  64  registered backdoor read data

## Operation
- The block has three FSM states: IDLE, DATA, RESP.
- IDLE:
  - When AWVALID is seen, the delay counter loads AW_DLY and counts down to 0.
  - When the counter reaches 0, AWREADY is driven for exactly one cycle.
  - On that handshake, the block latches AWID, AWADDR, AWLEN and AWSIZE, clears the beat counter and the error flag, and moves to DATA.
- DATA:
  - WREADY is held at 1.
  - Each W handshake writes WDATA into mem[addr[3 +: log2 MEM_WORDS]], one byte lane per set bit of WSTRB.
  - After each beat, addr += (1 << AWSIZE). The word index wraps modulo MEM_WORDS.
  - The beat counter increments per beat. The burst ends at beat AWLEN+1, regardless of WLAST; then WREADY drops and the FSM moves to RESP.
- Error flag: set to 1 on any of the following.
  - WLAST=1 on a non-final beat.
  - WLAST=0 on the final beat.
  - WID≠latched AWID on any beat.
  - AWSIZE>3.
- An errored burst still writes all of its beats.
- RESP:
  - BVALID=1, BID=latched AWID, BRESP = error ? 2 : 0.
  - BVALID and BID/BRESP are held stable until BREADY; then the FSM returns to IDLE.
- One outstanding transaction only. AWREADY is never asserted outside IDLE.
- dbg_rdata <= mem[dbg_addr] every cycle.
- Reset:
  - Outputs reset to AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, dbg_rdata=0.
  - FSM goes to IDLE; counters and the error flag clear.
  - Memory contents are not reset.
  - Reset asserted mid-burst abandons the burst. Beats already written remain in memory.

## Timing
- AWREADY rises AW_DLY cycles after the first cycle AWVALID is high in IDLE. With AW_DLY=0 it is the same cycle (combinational on AWVALID in IDLE).
- AWVALID dropping before AWREADY, which is illegal on AXI, returns the counter to reload; no handshake occurs.
- WREADY rises the cycle after the AW handshake and stays high until the final beat completes.
- BVALID rises the cycle after the final W handshake.
- Next AWREADY comes no earlier than the cycle after the B handshake.
- AW handshake to BVALID = AWLEN+2 cycles, with WVALID continuously high.
- Worst-case per-channel ready latency is at most 5 cycles, given an upstream master that keeps WVALID/BREADY responsive.
- Memory write is visible on dbg_rdata 2 cycles after the W handshake: 1 cycle for the write, 1 cycle for the registered read.

## Structure
- Shared package dma_axi_pkg holds:
  - the state enum {IDLE, DATA, RESP}
  - the BRESP constants OKAY=2'b00, SLVERR=2'b10
  - the width defaults
- One sub-module, dma_axi_bemem: single-write-port byte-enable memory with a registered read port.
- The FSM, counters and error logic live in the top module.

## Test plan
- Reset low for 3 cycles with AWVALID=1 -> all outputs 0. After release, AWREADY pulses AW_DLY cycles later.
- AWADDR=0x10, AWLEN=3, AWSIZE=3, AWID=5, data 0x11..0x44, WLAST on beat 4 -> words 2..5 hold 0x11, 0x22, 0x33, 0x44; BID=5, BRESP=0 at 5 cycles after AW handshake.
- Single beat to word 0 with WSTRB=8'h0F over preloaded 0xFFFF_FFFF_FFFF_FFFF, WDATA=0 -> dbg_rdata=0xFFFF_FFFF_0000_0000.
- AWLEN=1 with WLAST on beat 1 -> both beats are written, BRESP=2.
- Hold BREADY=0 for 4 cycles -> BVALID and BID stay stable; AWREADY stays 0 despite AWVALID=1 until 1 cycle after the B handshake.
- AWADDR at the last word (MEM_WORDS-1)*8, AWLEN=1 -> second beat lands in word 0 (wrap); BRESP=0.

Source files
------------

// File: rtl/dma_axi_wr_slave_pkg.sv
// Shared types and defaults for the DMA AXI write-channel slave.
// Holds the FSM state enum, the BRESP encodings and the default widths.
package dma_axi_pkg;

    localparam int DEF_ID_W      = 4;
    localparam int DEF_LEN_W     = 4;
    localparam int DEF_SIZE_W    = 2;
    localparam int DEF_MEM_WORDS = 256;
    localparam int DEF_AW_DLY    = 2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dma_axi_wr_slave_if.sv
// AW/W/B channel bundle between the DMA master port and the write slave.
interface dma_axi_wr_slave_if
    import dma_axi_pkg::*;
#(
    parameter int ID_W   = DEF_ID_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int SIZE_W = DEF_SIZE_W
);
    logic [ID_W-1:0]   AWID;
    logic [31:0]       AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [SIZE_W-1:0] AWSIZE;
    logic              AWVALID;
    logic              AWREADY;

    logic [ID_W-1:0]   WID;
    logic [63:0]       WDATA;
    logic [7:0]        WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;

    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWVALID,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWVALID,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );

endinterface

// File: rtl/dma_axi_wr_slave_bemem.sv
// Byte-enable 64-bit memory: one write port, one registered read port.
// Each byte lane is its own array so the tools can map lanes onto block RAM.
module dma_axi_bemem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wstrb,
    input  logic [63:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [63:0]   o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] r_lane_mem [WORDS];
            logic [7:0] r_lane_rd;

            always_ff @(posedge clk) begin
                if (i_we && i_wstrb[gi]) begin
                    r_lane_mem[i_waddr] <= i_wdata[gi*8 +: 8];
                end
            end

            // Read-before-write: a write is seen one cycle after it lands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lane_rd <= '0;
                end else begin
                    r_lane_rd <= r_lane_mem[i_raddr];
                end
            end

            assign o_rdata[gi*8 +: 8] = r_lane_rd;
        end
    endgenerate

endmodule

// File: rtl/dma_axi_wr_slave.sv
// AXI64 write-channel slave: accepts one AW/W burst at a time into a
// byte-enable memory and answers with OKAY or SLVERR on the B channel.
module dma_axi_wr_slave
    import dma_axi_pkg::*;
#(
    parameter int ID_W      = DEF_ID_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int SIZE_W    = DEF_SIZE_W,
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int AW_DLY    = DEF_AW_DLY,
    localparam int MEM_AW   = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    dma_axi_wr_slave_if.slave s_axi,
    input  logic [MEM_AW-1:0] i_dbg_addr,
    output logic [63:0]       o_dbg_rdata
);

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_dly_cnt;
    logic              r_dly_armed;
    logic [ID_W-1:0]   r_awid;
    logic [31:0]       r_addr;
    logic [LEN_W-1:0]  r_awlen;
    logic [SIZE_W-1:0] r_awsize;
    logic [LEN_W:0]    r_beat;
    logic              r_err;

    logic [2:0]        w_dly_cur;
    logic              w_awready;
    logic              w_wready;
    logic              w_bvalid;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_last_beat;
    logic              w_beat_err;
    logic              w_size_bad;

    // A fresh AWVALID starts from AW_DLY; an armed countdown continues.
    assign w_dly_cur   = r_dly_armed ? r_dly_cnt : 3'(AW_DLY);
    assign w_aw_hs     = s_axi.AWVALID && w_awready;
    assign w_w_hs      = s_axi.WVALID && w_wready;
    assign w_last_beat = (r_beat == {1'b0, r_awlen});
    assign w_beat_err  = (s_axi.WLAST != w_last_beat) || (s_axi.WID != r_awid);
    assign w_size_bad  = |(s_axi.AWSIZE >> 2);

    always_comb begin
        w_state_next = r_state;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_state)
            IDLE: begin
                // rst_n gate keeps AWREADY low during reset even with AW_DLY=0.
                w_awready = rst_n && s_axi.AWVALID && (w_dly_cur == 3'd0);
                if (w_awready) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                w_wready = 1'b1;
                if (s_axi.WVALID && w_last_beat) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.BREADY) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_cnt   <= '0;
            r_dly_armed <= 1'b0;
            r_awid      <= '0;
            r_addr      <= '0;
            r_awlen     <= '0;
            r_awsize    <= '0;
            r_beat      <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == IDLE && s_axi.AWVALID && !w_awready) begin
                r_dly_armed <= 1'b1;
                r_dly_cnt   <= w_dly_cur - 3'd1;
            end else begin
                r_dly_armed <= 1'b0;
                r_dly_cnt   <= '0;
            end

            if (w_aw_hs) begin
                r_awid   <= s_axi.AWID;
                r_addr   <= s_axi.AWADDR;
                r_awlen  <= s_axi.AWLEN;
                r_awsize <= s_axi.AWSIZE;
                r_beat   <= '0;
                r_err    <= w_size_bad;
            end else if (w_w_hs) begin
                r_addr <= r_addr + (32'd1 << r_awsize);
                r_beat <= r_beat + (LEN_W + 1)'(1);
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign s_axi.AWREADY = w_awready;
    assign s_axi.WREADY  = w_wready;
    assign s_axi.BVALID  = w_bvalid;
    assign s_axi.BID     = r_awid;
    assign s_axi.BRESP   = r_err ? SLVERR : OKAY;

    dma_axi_bemem #(
        .WORDS (MEM_WORDS),
        .AW    (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_w_hs),
        .i_waddr (r_addr[3 +: MEM_AW]),
        .i_wstrb (s_axi.WSTRB),
        .i_wdata (s_axi.WDATA),
        .i_raddr (i_dbg_addr),
        .o_rdata (o_dbg_rdata)
    );

endmodule

// File: tb/tb_dma_axi_wr_slave.sv
// Directed plus randomized bursts against a byte-level memory model and
// AXI response rules; each comparison is an immediate assertion.
module tb_dma_axi_wr_slave;
    import dma_axi_pkg::*;

    localparam int ID_W      = 4;
    localparam int LEN_W     = 4;
    localparam int SIZE_W    = 2;
    localparam int MEM_WORDS = 256;
    localparam int AW_DLY    = 2;
    localparam int MEM_AW    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_axi_wr_slave_if #(.ID_W(ID_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W)) bus ();
    logic [MEM_AW-1:0] dbg_addr;
    logic [63:0]       dbg_rdata;

    dma_axi_wr_slave #(
        .ID_W(ID_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W),
        .MEM_WORDS(MEM_WORDS), .AW_DLY(AW_DLY)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axi       (bus),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_rdata (dbg_rdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory: data plus a per-byte "has been written" mask.
    logic [63:0] m_data  [MEM_WORDS];
    logic [63:0] m_known [MEM_WORDS];

    logic [63:0]     b_data [16];
    logic [7:0]      b_strb [16];
    logic            b_last [16];
    logic [ID_W-1:0] b_wid  [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic fill_beats(input int len, input logic [ID_W-1:0] id,
                              input bit bad_last, input bit bad_id);
        int k;
        for (int i = 0; i <= len; i++) begin
            b_data[i] = {$urandom, $urandom};
            b_strb[i] = 8'($urandom);
            b_last[i] = (i == len);
            b_wid[i]  = id;
        end
        if (bad_last) begin
            k = $urandom_range(0, len);
            b_last[k] = ~b_last[k];
        end
        if (bad_id) begin
            k = $urandom_range(0, len);
            b_wid[k] = id ^ ID_W'($urandom_range(1, 15));
        end
    endtask

    task automatic readback_word(input int wi);
        dbg_addr = MEM_AW'(wi);
        @(negedge clk); #1;
        check($sformatf("mem[%0d]", wi), dbg_rdata & m_known[wi], m_data[wi] & m_known[wi]);
    endtask

    task automatic do_aw(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input int len, input int size, output int hs_cyc);
        int waits;
        waits = 0;
        bus.AWID    = id;
        bus.AWADDR  = addr;
        bus.AWLEN   = LEN_W'(len);
        bus.AWSIZE  = SIZE_W'(size);
        bus.AWVALID = 1'b1;
        #1;
        while (!bus.AWREADY && waits < 20) begin
            @(negedge clk); #1;
            waits++;
        end
        check("aw_latency", 64'(waits), 64'(AW_DLY));
        hs_cyc = cyc;
        @(negedge clk); #1;
        check("aw_pulse", 64'(bus.AWREADY), 64'd0);
        bus.AWVALID = 1'b0;
    endtask

    task automatic run_txn(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input int len, input int size, input bit gaps,
                           input int bstall, input bit hold_aw, input bit do_rb);
        int          hs_cyc;
        int          wi;
        logic        exp_err;
        logic [1:0]  exp_resp;
        logic [31:0] a;
        do_aw(id, addr, len, size, hs_cyc);
        exp_err = 1'b0;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.WVALID = 1'b0;
                    @(negedge clk);
                end
            end
            bus.WID    = b_wid[i];
            bus.WDATA  = b_data[i];
            bus.WSTRB  = b_strb[i];
            bus.WLAST  = b_last[i];
            bus.WVALID = 1'b1;
            #1;
            check("wready", 64'(bus.WREADY), 64'd1);
            @(negedge clk);
            wi = int'((a >> 3) % MEM_WORDS);
            for (int b = 0; b < 8; b++) begin
                if (b_strb[i][b]) begin
                    m_data[wi][b*8 +: 8]  = b_data[i][b*8 +: 8];
                    m_known[wi][b*8 +: 8] = 8'hFF;
                end
            end
            if ((b_last[i] != (i == len)) || (b_wid[i] != id)) exp_err = 1'b1;
            a = a + (32'd1 << size);
        end
        bus.WVALID = 1'b0;
        #1;
        exp_resp = exp_err ? SLVERR : OKAY;
        check("bvalid", 64'(bus.BVALID), 64'd1);
        check("wready_drop", 64'(bus.WREADY), 64'd0);
        if (!gaps) check("b_latency", 64'(cyc - hs_cyc), 64'(len + 2));
        check("bid", 64'(bus.BID), 64'(id));
        check("bresp", 64'(bus.BRESP), 64'(exp_resp));
        if (hold_aw) bus.AWVALID = 1'b1;
        repeat (bstall) begin
            @(negedge clk); #1;
            check("bvalid_hold", 64'(bus.BVALID), 64'd1);
            check("bid_hold", 64'(bus.BID), 64'(id));
            check("bresp_hold", 64'(bus.BRESP), 64'(exp_resp));
            check("aw_blocked", 64'(bus.AWREADY), 64'd0);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        #1;
        check("bvalid_clr", 64'(bus.BVALID), 64'd0);
        check("aw_after_b", 64'(bus.AWREADY), 64'(AW_DLY == 0 && bus.AWVALID));
        $display("txn id=%0d addr=%h len=%0d size=%0d resp=%0d", id, addr, len, size, exp_resp);
        if (do_rb) begin
            a = addr;
            for (int i = 0; i <= len; i++) begin
                readback_word(int'((a >> 3) % MEM_WORDS));
                a = a + (32'd1 << size);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ID_W-1:0] rid;
        int rlen, rsize, rstall;
        bit  rbl, rbi, rgap;
        logic [31:0] raddr;

        for (int w = 0; w < MEM_WORDS; w++) begin
            m_data[w]  = '0;
            m_known[w] = '0;
        end
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
        bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.AWVALID = 1'b1;
        dbg_addr = '0;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_awready", 64'(bus.AWREADY), 64'd0);
        check("rst_wready", 64'(bus.WREADY), 64'd0);
        check("rst_bvalid", 64'(bus.BVALID), 64'd0);
        check("rst_bid", 64'(bus.BID), 64'd0);
        check("rst_bresp", 64'(bus.BRESP), 64'd0);
        check("rst_dbg", dbg_rdata, 64'd0);
        rst_n = 1'b1;

        // Four-beat burst to words 2..5, straight out of reset.
        for (int i = 0; i < 4; i++) begin
            b_data[i] = 64'(8'h11 * (i + 1));
            b_strb[i] = 8'hFF;
            b_last[i] = (i == 3);
            b_wid[i]  = 4'd5;
        end
        run_txn(4'd5, 32'h10, 3, 3, 1'b0, 0, 1'b0, 1'b1);
        dbg_addr = 8'd5;
        @(negedge clk); #1;
        check("word5", dbg_rdata, 64'h44);

        // AWVALID withdrawn early: the countdown must restart from AW_DLY.
        bus.AWVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0;
        @(negedge clk);

        b_data[0] = '1; b_strb[0] = 8'hFF; b_last[0] = 1'b1; b_wid[0] = 4'd1;
        run_txn(4'd1, 32'h0, 0, 3, 1'b0, 0, 1'b0, 1'b0);
        b_data[0] = '0; b_strb[0] = 8'h0F;
        run_txn(4'd1, 32'h0, 0, 3, 1'b0, 0, 1'b0, 1'b1);
        dbg_addr = 8'd0;
        @(negedge clk); #1;
        check("strb_merge", dbg_rdata, 64'hFFFF_FFFF_0000_0000);

        // Early WLAST: both beats land, response is SLVERR.
        fill_beats(1, 4'd3, 1'b0, 1'b0);
        b_last[0] = 1'b1; b_last[1] = 1'b0;
        run_txn(4'd3, 32'h100, 1, 3, 1'b0, 0, 1'b0, 1'b1);

        // BREADY stall with AWVALID pending; the next burst wraps the memory.
        fill_beats(2, 4'd7, 1'b0, 1'b0);
        run_txn(4'd7, 32'h200, 2, 3, 1'b0, 4, 1'b1, 1'b0);
        fill_beats(1, 4'd2, 1'b0, 1'b0);
        run_txn(4'd2, 32'((MEM_WORDS - 1) * 8), 1, 3, 1'b0, 0, 1'b0, 1'b1);

        for (int t = 0; t < 24; t++) begin
            rid    = ID_W'($urandom);
            rlen   = $urandom_range(0, 7);
            rsize  = $urandom_range(0, 3);
            raddr  = $urandom;
            rbl    = ($urandom_range(0, 3) == 0);
            rbi    = ($urandom_range(0, 3) == 0);
            rgap   = ($urandom_range(0, 1) == 1);
            rstall = $urandom_range(0, 3);
            fill_beats(rlen, rid, rbl, rbi);
            run_txn(rid, raddr, rlen, rsize, rgap, rstall, 1'b0, 1'b1);
        end

        for (int w = 0; w < MEM_WORDS; w++) begin
            if (m_known[w] != 64'd0) readback_word(w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
